// File: rtl/fact_ctrl.sv
// fact_ctrl: Moore control FSM for the factorial datapath, four-phase go/done handshake.
// Optional MUL-iteration watchdog compiled in with `define FACT_CTRL_WATCHDOG_EN.
//
// state | meaning
// IDLE  | waiting for go; error_in sampled here
// LOAD  | counter <= n, product register <= 1
// CHECK | test compared (counter > 1)
// MUL   | register <= cnt * reg, counter decrements
// DONE  | result presented on product, held while go stays high
// ERR   | run aborted (range error or watchdog), held while go stays high
module fact_ctrl
`ifdef FACT_CTRL_WATCHDOG_EN
#(
    parameter int MAX_ITER = 12
)
`endif
(
    input  logic clk,
    input  logic rst,
    input  logic go,
    input  logic compared,
    input  logic error_in,
    output logic sel1,
    output logic sel2,
    output logic load_cnt,
    output logic load_reg,
    output logic en,
    output logic busy,
    output logic done,
    output logic err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CHECK = 3'd2,
        MUL   = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   wd_trip;

`ifdef FACT_CTRL_WATCHDOG_EN
    logic [3:0] iter_cnt;

    // Counts MUL entries; a stuck compared flag trips after MAX_ITER iterations.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            iter_cnt <= '0;
        end else if (state == LOAD) begin
            iter_cnt <= '0;
        end else if (state == CHECK && state_nxt == MUL) begin
            iter_cnt <= iter_cnt + 4'd1;
        end
    end

    assign wd_trip = (iter_cnt == 4'(MAX_ITER));
`else
    assign wd_trip = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sel1      = 1'b0;
        sel2      = 1'b0;
        load_cnt  = 1'b0;
        load_reg  = 1'b0;
        en        = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        case (state)
            IDLE: begin
                if (go) begin
                    state_nxt = error_in ? ERR : LOAD;
                end
            end
            LOAD: begin
                load_cnt  = 1'b1;
                load_reg  = 1'b1;
                busy      = 1'b1;
                state_nxt = CHECK;
            end
            CHECK: begin
                busy = 1'b1;
                if (compared) begin
                    state_nxt = wd_trip ? ERR : MUL;
                end else begin
                    state_nxt = DONE;
                end
            end
            MUL: begin
                sel1      = 1'b1;
                load_reg  = 1'b1;
                en        = 1'b1;
                busy      = 1'b1;
                state_nxt = CHECK;
            end
            DONE: begin
                done = 1'b1;
                sel2 = 1'b1;
                if (!go) begin
                    state_nxt = IDLE;
                end
            end
            ERR: begin
                done = 1'b1;
                err  = 1'b1;
                sel2 = 1'b1;
                if (!go) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fact_ctrl.sv
// Bench for fact_ctrl: a behavioural factorial datapath around the controller,
// directed runs with hand-computed results checked by a done-driven scoreboard.
module tb_fact_ctrl;

    typedef struct {
        bit          no_done;
        int          lat;
        logic [31:0] prod;
        bit          err;
        int          muls;
        bit          strobes;
        int          width;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        go;
    logic        compared;
    logic        error_in;
    logic        sel1, sel2, load_cnt, load_reg, en, busy, done, err;
    logic [4:0]  n;
    logic [4:0]  cnt;
    logic [31:0] regv;
    logic [31:0] product;
    logic        force_cmp;

    int   checks = 0;
    int   failures = 0;
    exp_t q[$];
    exp_t cur;
    bit   running = 0;
    bit   prev_idle = 1;
    bit   prev_done = 0;
    bit   have_cur = 0;
    bit   strobes = 0;
    bit   end_req;
    bit   end_ack = 0;
    bit   idle_now;
    int   cyc = 0;
    int   mul_cnt = 0;
    int   dw = 0;

    always #5 clk = ~clk;

    fact_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .go       (go),
        .compared (compared),
        .error_in (error_in),
        .sel1     (sel1),
        .sel2     (sel2),
        .load_cnt (load_cnt),
        .load_reg (load_reg),
        .en       (en),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    // Datapath model: counter, product register, multiplier, output mux.
    assign error_in = (n > 5'd12);
    assign compared = force_cmp || (cnt > 5'd1);
    assign product  = sel2 ? regv : 32'd0;

    always @(posedge clk) begin
        if (load_cnt) cnt <= n;
        else if (en) cnt <= cnt - 5'd1;
        if (load_reg) regv <= sel1 ? (32'(cnt) * regv) : 32'd1;
    end

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic chk_min(input string name, input longint act, input longint lo);
        checks++;
        if (act < lo) begin
            failures++;
            $display("FAIL %s: actual=%0d required_at_least=%0d", name, act, lo);
        end
    endtask

    // Monitor: tracks each run from its first non-idle cycle and scores it when done rises.
    always @(negedge clk or negedge rst) begin
        if (!rst) begin
            #1;
            chk("reset_outputs", {sel1, sel2, load_cnt, load_reg, en, busy, done, err}, 0);
            if (running && q.size() > 0 && q[0].no_done) begin
                cur = q.pop_front();
                chk_min("stuck_cycles_without_done", cyc, cur.lat);
                chk_min("stuck_mul_cycles", mul_cnt, cur.muls);
            end
            running   = 0;
            prev_idle = 1;
            prev_done = 0;
            have_cur  = 0;
        end else begin
            idle_now = !busy && !done;
            if (prev_idle && !idle_now) begin
                running = 1;
                cyc     = 1;
                mul_cnt = 0;
                strobes = 0;
            end else if (running) begin
                cyc++;
            end
            if (running) begin
                if (en) mul_cnt++;
                if (load_cnt || load_reg || en) strobes = 1;
                if (cyc > 80) begin
                    checks++;
                    failures++;
                    $display("FAIL run_timeout: actual=%0d cycles without done required<=80", cyc);
                    running = 0;
                end
            end
            if (done && !prev_done) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: actual=1 required=0");
                    have_cur = 0;
                end else begin
                    cur      = q.pop_front();
                    have_cur = 1;
                    if (cur.no_done) begin
                        checks++;
                        failures++;
                        $display("FAIL done_on_stuck_run: actual=1 required=0 at cycle %0d", cyc);
                    end
                    chk("latency", cyc, cur.lat);
                    chk("err", err, cur.err);
                    if (!cur.err) chk("product", product, cur.prod);
                    chk("mul_cycles", mul_cnt, cur.muls);
                    chk("strobes_seen", strobes, cur.strobes);
                end
                running = 0;
                dw      = 1;
                chk("no_strobe_in_done", {load_cnt, load_reg, en, busy}, 0);
            end else if (done) begin
                dw++;
                if (have_cur && !cur.err) chk("product_stable", product, cur.prod);
                chk("no_strobe_in_done", {load_cnt, load_reg, en, busy}, 0);
            end else if (prev_done) begin
                if (have_cur) begin
                    chk("done_width", dw, cur.width);
                    chk("idle_after_done", {busy, err}, 0);
                end
                have_cur = 0;
            end
            if (end_req && !end_ack) begin
                chk("queue_drained", q.size(), 0);
                end_ack = 1;
            end
            prev_idle = idle_now;
            prev_done = done;
        end
    end

    task automatic wait_level(input logic lvl, input int max);
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (done === lvl) break;
        end
    endtask

    task automatic push_exp(input bit nd, input int lat, input logic [31:0] prod, input bit e,
                            input int muls, input bit strb, input int width);
        exp_t x;
        x.no_done = nd;
        x.lat     = lat;
        x.prod    = prod;
        x.err     = e;
        x.muls    = muls;
        x.strobes = strb;
        x.width   = width;
        q.push_back(x);
    endtask

    // hold: extra cycles go stays high after done; drop: cycles before go falls mid-run (0 = hold mode).
    task automatic run(input int nv, input int hold, input int drop, input int lat,
                       input logic [31:0] prod, input bit e, input int muls,
                       input bit strb, input int width);
        push_exp(0, lat, prod, e, muls, strb, width);
        @(negedge clk);
        n  = 5'(nv);
        go = 1'b1;
        if (drop > 0) begin
            repeat (drop) @(negedge clk);
            go = 1'b0;
        end
        wait_level(1'b1, 60);
        if (drop == 0) begin
            repeat (hold) @(negedge clk);
            go = 1'b0;
        end
        wait_level(1'b0, 20);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        rst       = 1'b1;
        go        = 1'b0;
        n         = 5'd0;
        force_cmp = 1'b0;
        end_req   = 1'b0;
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        //  n  hold drop lat  product     err muls strobes width
        run(5,  3,   0,  11, 32'd120,       0, 4,   1,      4);
        run(0,  0,   0,  3,  32'd1,         0, 0,   1,      1);
        run(1,  0,   0,  3,  32'd1,         0, 0,   1,      1);
        run(13, 2,   0,  1,  32'd0,         1, 0,   0,      3);
        run(12, 0,   2,  25, 32'd479001600, 0, 11,  1,      1);
        run(3,  0,   0,  7,  32'd6,         0, 2,   1,      1);

        // Asynchronous reset in the middle of MUL, then a full restart with go held.
        @(negedge clk);
        n  = 5'd8;
        go = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (en) break;
        end
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        push_exp(0, 17, 32'd40320, 0, 7, 1, 1);
        @(negedge clk);
        rst = 1'b1;
        wait_level(1'b1, 60);
        go = 1'b0;
        wait_level(1'b0, 20);
        repeat (2) @(negedge clk);

        // compared stuck high.
`ifdef FACT_CTRL_WATCHDOG_EN
        force_cmp = 1'b1;
        run(5, 0, 0, 27, 32'd0, 1, 12, 1, 1);
        force_cmp = 1'b0;
`else
        push_exp(1, 40, 32'd0, 0, 19, 1, 0);
        @(negedge clk);
        force_cmp = 1'b1;
        n  = 5'd5;
        go = 1'b1;
        repeat (41) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        go        = 1'b0;
        force_cmp = 1'b0;
        rst       = 1'b1;
        repeat (2) @(negedge clk);
`endif

        end_req = 1'b1;
        for (int i = 0; i < 10 && !end_ack; i++) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
